// File: rtl/fft_8_stream_ctrl.sv
// Serial valid/ready sequencer around a combinational 8-point FFT core.
// fft_8: radix-2 DIF, wrapping two's-complement arithmetic, no scaling.

module fft_8 #(
    parameter int unsigned N = 4
) (
    input  logic [8*(2**N)-1:0] in_r,
    input  logic [8*(2**N)-1:0] in_i,
    output logic [8*(2**N)-1:0] out_r,
    output logic [8*(2**N)-1:0] out_i
);
    localparam int unsigned W = 2**N;

    // Odd twiddles scale by 181/256 ~ 1/sqrt(2), floor-truncated.
    function automatic logic signed [W-1:0] mulc(input logic signed [W-1:0] v);
        logic signed [W+8:0] vx;
        logic signed [W+8:0] kc;
        logic signed [W+8:0] p;
        vx = (W+9)'(v);
        kc = (W+9)'(181);
        p  = vx * kc;
        return p[W+7:8];
    endfunction

    function automatic logic [2:0] rev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    logic signed [W-1:0] xr [8];
    logic signed [W-1:0] xi [8];
    logic signed [W-1:0] dr [4];
    logic signed [W-1:0] di [4];
    logic signed [W-1:0] s1r [8];
    logic signed [W-1:0] s1i [8];
    logic signed [W-1:0] s2r [8];
    logic signed [W-1:0] s2i [8];
    logic signed [W-1:0] s3r [8];
    logic signed [W-1:0] s3i [8];

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            xr[k] = in_r[k*W +: W];
            xi[k] = in_i[k*W +: W];
        end
        for (int n = 0; n < 4; n++) begin
            s1r[n] = xr[n] + xr[n+4];
            s1i[n] = xi[n] + xi[n+4];
            dr[n]  = xr[n] - xr[n+4];
            di[n]  = xi[n] - xi[n+4];
        end
        s1r[4] = dr[0];
        s1i[4] = di[0];
        s1r[5] = mulc(dr[1] + di[1]);
        s1i[5] = mulc(di[1] - dr[1]);
        s1r[6] = di[2];
        s1i[6] = -dr[2];
        s1r[7] = mulc(di[3] - dr[3]);
        s1i[7] = mulc(-dr[3] - di[3]);
        for (int h = 0; h < 8; h += 4) begin
            s2r[h]   = s1r[h] + s1r[h+2];
            s2i[h]   = s1i[h] + s1i[h+2];
            s2r[h+1] = s1r[h+1] + s1r[h+3];
            s2i[h+1] = s1i[h+1] + s1i[h+3];
            s2r[h+2] = s1r[h] - s1r[h+2];
            s2i[h+2] = s1i[h] - s1i[h+2];
            s2r[h+3] = s1i[h+1] - s1i[h+3];
            s2i[h+3] = s1r[h+3] - s1r[h+1];
        end
        for (int m = 0; m < 8; m += 2) begin
            s3r[m]   = s2r[m] + s2r[m+1];
            s3i[m]   = s2i[m] + s2i[m+1];
            s3r[m+1] = s2r[m] - s2r[m+1];
            s3i[m+1] = s2i[m] - s2i[m+1];
        end
        // DIF leaves bins in bit-reversed order.
        for (int k = 0; k < 8; k++) begin
            out_r[k*W +: W] = s3r[rev3(3'(k))];
            out_i[k*W +: W] = s3i[rev3(3'(k))];
        end
    end
endmodule

module fft_8_stream_ctrl #(
    parameter int unsigned N = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**N-1:0] in_r,
    input  logic [2**N-1:0] in_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**N-1:0] out_r,
    output logic [2**N-1:0] out_i,
    output logic [2:0]      out_idx,
    output logic            out_last,
    output logic            busy,
    output logic [15:0]     frame_cnt
);
    localparam int unsigned W = 2**N;

    typedef enum logic [1:0] {StLoad, StCompute, StUnload} state_e;

    state_e         state_q;
    logic [2:0]     load_cnt_q;
    logic [2:0]     unload_cnt_q;
    logic [15:0]    frame_cnt_q;
    logic [15:0]    frame_cnt_d;
    logic [W-1:0]   buf_r_q [8];
    logic [W-1:0]   buf_i_q [8];
    logic [W-1:0]   res_r_q [8];
    logic [W-1:0]   res_i_q [8];
    logic [8*W-1:0] core_in_r;
    logic [8*W-1:0] core_in_i;
    logic [8*W-1:0] core_out_r;
    logic [8*W-1:0] core_out_i;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            core_in_r[k*W +: W] = buf_r_q[k];
            core_in_i[k*W +: W] = buf_i_q[k];
        end
    end

    fft_8 #(
        .N(N)
    ) u_core (
        .in_r (core_in_r),
        .in_i (core_in_i),
        .out_r(core_out_r),
        .out_i(core_out_i)
    );

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_q == StUnload && out_ready && unload_cnt_q == 3'd7) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            load_cnt_q   <= 3'd0;
            unload_cnt_q <= 3'd0;
            frame_cnt_q  <= 16'd0;
            for (int k = 0; k < 8; k++) begin
                buf_r_q[k] <= '0;
                buf_i_q[k] <= '0;
                res_r_q[k] <= '0;
                res_i_q[k] <= '0;
            end
        end else begin
            frame_cnt_q <= frame_cnt_d;
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        buf_r_q[load_cnt_q] <= in_r;
                        buf_i_q[load_cnt_q] <= in_i;
                        load_cnt_q          <= load_cnt_q + 3'd1;
                        if (load_cnt_q == 3'd7) begin
                            state_q <= StCompute;
                        end
                    end
                end
                StCompute: begin
                    for (int k = 0; k < 8; k++) begin
                        res_r_q[k] <= core_out_r[k*W +: W];
                        res_i_q[k] <= core_out_i[k*W +: W];
                    end
                    unload_cnt_q <= 3'd0;
                    state_q      <= StUnload;
                end
                StUnload: begin
                    if (out_ready) begin
                        unload_cnt_q <= unload_cnt_q + 3'd1;
                        if (unload_cnt_q == 3'd7) begin
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StUnload);
    assign busy      = (state_q != StLoad);
    assign out_idx   = unload_cnt_q;
    assign out_last  = (state_q == StUnload) && (unload_cnt_q == 3'd7);
    assign out_r     = res_r_q[unload_cnt_q];
    assign out_i     = res_i_q[unload_cnt_q];
    assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/fft_8_stream_ctrl.md
Name: fft_8_stream_ctrl

Overview:
- Sequencer wrapping one combinational fft_8 core (instantiated inside, same N).
- Converts the core's 8-wide parallel interface into a serial valid/ready sample stream.
- Collects 8 complex input samples, presents the frame to the core, captures the core outputs, then streams 8 complex results out in index order.
- Sits between the sample source (ADC/FIFO side) and downstream consumers of spectral bins.

Parameters:
- N, 4, log2 of the sample word width; every real/imag word is 2**N bits (same meaning as in fft_8).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept an input sample.
- in_r  in  2**N  input sample, real part.
- in_i  in  2**N  input sample, imaginary part.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts the output bin.
- out_r  out  2**N  output bin, real part.
- out_i  out  2**N  output bin, imaginary part.
- out_idx  out  3  bin index (0..7) of the current output.
- out_last  out  1  high with bin 7.
- busy  out  1  high in COMPUTE and UNLOAD.
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = LOAD, load_cnt = 0, unload_cnt = 0, frame_cnt = 0.
  - in_ready = 1 on the cycle after reset; out_valid = 0, out_last = 0, busy = 0, out_idx = 0, out_r/out_i = 0.
  - All 8 input buffer entries and all 8 result registers clear to 0.
  - Reset mid-frame discards partial input and any pending results; nothing is emitted.
- Handshakes: a transfer occurs on an edge where valid && ready. Sources must hold data stable while valid && !ready; the block holds out_* stable while out_valid && !out_ready.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - On an input transfer: buf[load_cnt] <= {in_r, in_i}; load_cnt increments.
  - The transfer with load_cnt == 7 moves to COMPUTE and resets load_cnt to 0.
  - in_valid low holds state; gaps between samples are allowed.
- COMPUTE (exactly 1 cycle):
  - in_ready = 0, busy = 1.
  - The core sees buf[0..7] on its in_k ports.
  - At the edge, res[k] <= core out_k for all k, unload_cnt <= 0, then move to UNLOAD.
- UNLOAD:
  - out_valid = 1, busy = 1, in_ready = 0.
  - out_r/out_i = res[unload_cnt], out_idx = unload_cnt, out_last = (unload_cnt == 7).
  - Each output transfer increments unload_cnt.
  - The transfer with unload_cnt == 7 increments frame_cnt and returns to LOAD. in_ready is high the next cycle.
  - out_ready low stalls indefinitely with outputs stable.
- Outputs are driven from registers and state only; there is no combinational path from in_* or out_ready to any output.
- Latency:
  - From accepting sample 7 to the first out_valid: 2 cycles (COMPUTE, then UNLOAD).
  - Minimum frame period with in_valid and out_ready held high: 8 load + 1 compute + 8 unload = 17 cycles.
- Arithmetic: none in this block. Values pass through the core bit-exact, with no rescaling or saturation; width and overflow behaviour are those of fft_8.
- Input samples presented while not in LOAD are ignored (in_ready = 0); the source holds them.

Test Plan:
- Reset/idle: hold rst_n = 0 for 3 cycles, release -> in_ready = 1, out_valid = 0, busy = 0, frame_cnt = 0, out_r = out_i = 0.
- Impulse frame, back-to-back:
  - Stimulus: in_r = 0x0100, in_i = 0 for sample 0; zeros for samples 1..7; out_ready = 1.
  - Required: out_valid rises 2 cycles after sample 7 is accepted; 8 bins with out_idx 0..7 match a separately instantiated fft_8 fed the same vector.
  - Required: out_last is high only at idx 7; frame_cnt = 1; in_ready is back at cycle 17.
- Source gaps and output backpressure:
  - Stimulus: in_valid toggled 1/0 every cycle while loading ramp samples in_r = k*0x0010; out_ready = 0 for 5 cycles at idx 3.
  - Required: buffer captures samples in order; idx 3 held stable for 5 cycles; no bin dropped or duplicated; in_ready stays 0 throughout UNLOAD.
- Mid-operation reset:
  - Stimulus: assert rst_n = 0 after 5 samples loaded, then after release run a DC frame (all in_r = 0x0040).
  - Required: no output from the aborted frame; result equals the fft_8 output for the DC vector; frame_cnt = 1.
- frame_cnt wrap: force frame_cnt to 0xFFFF and complete one frame -> frame_cnt = 0x0000.
- Continuous stream: 4 random frames with in_valid and out_ready always 1 -> 68 cycles total; every bin bit-exact versus fft_8.
